// File: rtl/rotor_inverse_stage_if.sv
// Valid/ready letter channel used on both sides of the inverse rotor stage.
// The master drives valid/letter; the slave drives ready.
interface rotor_inverse_stage_if;
  logic       valid;
  logic       ready;
  logic [4:0] letter;

  modport master (output valid, output letter, input ready);
  modport slave  (input valid, input letter, output ready);
endinterface

// File: rtl/rotor_inverse_stage.sv
// Return-path Enigma rotor stage: inverse wiring offset by the rotor position, one register slot.
// Optional ROTOR_INV_RING_EN adds a ring_setting input that is subtracted from the position offset.
module rotor_inverse_stage #(
  parameter int unsigned NOTCH_POS = 16,
  parameter int unsigned MAX_POS   = 25
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load_pos,
  input  logic [4:0]                    init_pos,
  input  logic                          step,
`ifdef ROTOR_INV_RING_EN
  input  logic [4:0]                    ring_setting,
`endif
  rotor_inverse_stage_if.slave          in_bus,
  rotor_inverse_stage_if.master         out_bus,
  output logic [7:0]                    position,
  output logic                          carry_out
);

  localparam logic [5:0] MODULUS = 6'(MAX_POS + 1);
  localparam logic [4:0] MAX_P   = 5'(MAX_POS);
  localparam logic [4:0] NOTCH   = 5'(NOTCH_POS);

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t      slot_q;
  logic [4:0] letter_q;
  logic [4:0] pos_q;
  logic       carry_q;

  logic       accept;
  logic [4:0] letter_c;
  logic [4:0] offset;
  logic [4:0] idx;
  logic [4:0] wired;
  logic [4:0] mapped;
  logic [4:0] load_val;
  logic [4:0] step_val;

  function automatic logic [4:0] mod_reduce(input logic [5:0] v);
    return (v >= MODULUS) ? 5'(v - MODULUS) : v[4:0];
  endfunction

  // Inverse of EKMFLGDQVZNTOWYHXUSPAIBRCJ, i.e. "UWYGADFPVZBECKMTHXSLRINQOJ".
  function automatic logic [4:0] inv_wire(input logic [4:0] i);
    logic [4:0] r;
    case (i)
      5'd0:    r = 5'd20;
      5'd1:    r = 5'd22;
      5'd2:    r = 5'd24;
      5'd3:    r = 5'd6;
      5'd4:    r = 5'd0;
      5'd5:    r = 5'd3;
      5'd6:    r = 5'd5;
      5'd7:    r = 5'd15;
      5'd8:    r = 5'd21;
      5'd9:    r = 5'd25;
      5'd10:   r = 5'd1;
      5'd11:   r = 5'd4;
      5'd12:   r = 5'd2;
      5'd13:   r = 5'd10;
      5'd14:   r = 5'd12;
      5'd15:   r = 5'd19;
      5'd16:   r = 5'd7;
      5'd17:   r = 5'd23;
      5'd18:   r = 5'd18;
      5'd19:   r = 5'd11;
      5'd20:   r = 5'd17;
      5'd21:   r = 5'd8;
      5'd22:   r = 5'd13;
      5'd23:   r = 5'd16;
      5'd24:   r = 5'd14;
      5'd25:   r = 5'd9;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign in_bus.ready   = (slot_q == EMPTY) || out_bus.ready;
  assign out_bus.valid  = (slot_q == FULL);
  assign out_bus.letter = letter_q;
  assign position       = {3'b000, pos_q};
  assign carry_out      = carry_q;

  always_comb begin
    accept   = in_bus.valid && in_bus.ready;
    letter_c = (in_bus.letter > MAX_P) ? '0 : in_bus.letter;
`ifdef ROTOR_INV_RING_EN
    offset   = mod_reduce({1'b0, pos_q} + MODULUS
                          - {1'b0, ((ring_setting > MAX_P) ? 5'd0 : ring_setting)});
`else
    offset   = pos_q;
`endif
    idx      = mod_reduce({1'b0, letter_c} + {1'b0, offset});
    wired    = inv_wire(idx);
    // Adding the modulus before subtracting keeps the 6-bit intermediate non-negative.
    mapped   = mod_reduce({1'b0, wired} + MODULUS - {1'b0, offset});
    load_val = (init_pos > MAX_P) ? '0 : init_pos;
    step_val = (pos_q == MAX_P) ? '0 : pos_q + 5'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q   <= EMPTY;
      letter_q <= '0;
      pos_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        slot_q   <= FULL;
        letter_q <= mapped;
      end else if (out_bus.ready) begin
        slot_q   <= EMPTY;
      end

      carry_q <= 1'b0;
      if (load_pos) begin
        pos_q <= load_val;
      end else if (step) begin
        pos_q   <= step_val;
        carry_q <= (pos_q == NOTCH);
      end
    end
  end

endmodule
